// File: rtl/activation_scheduler.sv
// activation_scheduler: round-robin sharing of one combinational sigmoid unit among NREQ requesters.
// Latency: a transfer at edge k presents rsp_valid after edge k+1 when the output stage is free.
// Backpressure: rsp_ready low holds S2 and then S1; grants stop once both stages are full.
module activation_scheduler #(
  parameter int NREQ = 4,
  parameter int W    = 16,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      act_in,
  input  logic [W-1:0]      act_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy
);

  // Stage 1: operand presented to the activation unit
  logic            r_s1_v;
  logic [W-1:0]    r_act_in;
  logic [IDW-1:0]  r_s1_id;
  // Round-robin pointer: index of the most recent winner
  logic [IDW-1:0]  r_ptr;
  // Stage 2: captured activation result
  logic            r_rsp_valid;
  logic [W-1:0]    r_rsp_data;
  logic [IDW-1:0]  r_rsp_id;

  logic            w_s2_en;
  logic            w_s1_en;
  logic            w_gnt_found;
  logic [IDW-1:0]  w_gnt_id;
  logic [IDW-1:0]  w_idx;
  logic [NREQ-1:0] w_grant;
  logic [W-1:0]    w_gnt_dat;

  // S2 loads whenever S1 has data and the output slot is empty or draining;
  // S1 may load whenever it is empty or moving into S2.
  assign w_s2_en = r_s1_v & (~r_rsp_valid | rsp_ready);
  assign w_s1_en = ~r_s1_v | w_s2_en;

  // Find the first valid requester after the last winner, wrapping modulo NREQ.
  // NREQ is a power of two, so plain IDW-bit addition wraps correctly.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    w_idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = r_ptr + IDW'(k);
      if (!w_gnt_found && req_valid[w_idx]) begin
        w_gnt_found = 1'b1;
        w_gnt_id    = w_idx;
      end
    end
  end

  // One-hot grant; forced low during reset so no requester sees an acceptance.
  always_comb begin
    w_grant = '0;
    if (w_s1_en && w_gnt_found && !rst) begin
      w_grant[w_gnt_id] = 1'b1;
    end
  end

  assign w_gnt_dat = req_data[w_gnt_id*W +: W];

  // S1 update: capture the winner, or empty the stage when nothing is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v   <= 1'b0;
      r_act_in <= '0;
      r_s1_id  <= '0;
      r_ptr    <= IDW'(NREQ - 1);
    end else if (w_s1_en) begin
      if (|w_grant) begin
        r_s1_v   <= 1'b1;
        r_act_in <= w_gnt_dat;
        r_s1_id  <= w_gnt_id;
        r_ptr    <= w_gnt_id;
      end else begin
        r_s1_v   <= 1'b0;
      end
    end
  end

  // S2 update: capture the activation result, or clear once it has been taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
    end else if (w_s2_en) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= act_out;
      r_rsp_id    <= r_s1_id;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign req_ready = w_grant;
  assign act_in    = r_act_in;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign busy      = r_s1_v | r_rsp_valid;

endmodule

// File: tb/tb_activation_scheduler.sv
// tb_activation_scheduler: directed and randomized checks of activation_scheduler.
// A queue holds expected responses in grant order; a negedge monitor compares them.
// A hard-sigmoid model stands in for the external activation unit.
module tb_activation_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [W-1:0]      act_in;
  logic [W-1:0]      act_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              busy;

  always #5 clk = ~clk;

  // Hard sigmoid in Q8.8: clamp(x/4 + 0.5, 0, 1)
  function automatic logic [W-1:0] sig(input logic [W-1:0] x);
    int v;
    v = (int'($signed(x)) >>> 2) + 128;
    if (v < 0)   v = 0;
    if (v > 256) v = 256;
    return W'(v);
  endfunction

  assign act_out = sig(act_in);

  activation_scheduler #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .act_in    (act_in),
    .act_out   (act_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Scoreboard state
  typedef struct {
    int          id;
    logic [W-1:0] dat;
    int          t;
  } ent_t;

  ent_t         sbq[$];
  ent_t         e;
  int           cyc = 0;
  int           inflight = 0;
  int           mptr = NREQ - 1;
  int           gid;
  int           jj;
  int           xfer_cnt = 0;
  int           rsp_cnt = 0;
  logic [NREQ-1:0] exp_rdy;
  logic         hs;
  logic         stall_prev = 1'b0;
  logic [W-1:0] prev_dat;
  logic [IDW-1:0] prev_id;

  // Monitor: model the grant, queue accepted operands, compare responses.
  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        sbq.delete();
        inflight   = 0;
        mptr       = NREQ - 1;
        stall_prev = 1'b0;
      end else begin
        chk("busy", busy, inflight != 0);
        if (stall_prev) begin
          chk("hold_vld", rsp_valid, 1'b1);
          chk("hold_dat", rsp_data, prev_dat);
          chk("hold_id", rsp_id, prev_id);
        end
        // Two slots in flight; a full pipeline only accepts while the output drains.
        exp_rdy = '0;
        gid = -1;
        if (inflight < 2 || rsp_ready) begin
          for (int k = 1; k <= NREQ; k++) begin
            jj = (mptr + k) % NREQ;
            if (gid < 0 && req_valid[jj]) gid = jj;
          end
        end
        if (gid >= 0) exp_rdy[gid] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        hs = rsp_valid && rsp_ready;
        if (hs) begin
          rsp_cnt++;
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp actual id=%0d data=%0h required none t=%0t", rsp_id, rsp_data, $time);
          end else begin
            e = sbq.pop_front();
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_data", rsp_data, e.dat);
            chk("rsp_latency", cyc >= e.t + 2, 1'b1);
          end
        end
        if (gid >= 0) begin
          e.id  = gid;
          e.dat = sig(req_data[gid*W +: W]);
          e.t   = cyc;
          sbq.push_back(e);
          mptr = gid;
          xfer_cnt++;
        end
        inflight = inflight + ((gid >= 0) ? 1 : 0) - (hs ? 1 : 0);
        stall_prev = rsp_valid && !rsp_ready;
        prev_dat   = rsp_data;
        prev_id    = rsp_id;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] v);
    req_data[i*W +: W] = v;
  endtask

  task automatic chk_zero_state(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_act_in"}, act_in, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
  endtask

  int snap_x;
  int snap_r;
  int wait_n;

  initial begin : stim
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk_zero_state("por");

    // Single request from requester 2
    set_op(2, 16'h0700);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    chk("single_rdy", req_ready, 4'b0100);
    tick();
    chk("single_act_in", act_in, 16'h0700);
    req_valid = '0;
    tick();
    chk("single_rsp_valid", rsp_valid, 1'b1);
    chk("single_rsp_data", rsp_data, 16'h0100);
    chk("single_rsp_id", rsp_id, 2);
    tick();

    // Priority rotation: 3 alone, then 0 and 3 together
    set_op(0, 16'h0040);
    set_op(3, 16'hFF00);
    req_valid = 4'b1000;
    #1;
    chk("rot_first3", req_ready, 4'b1000);
    tick();
    req_valid = 4'b1001;
    #1;
    chk("rot_then0", req_ready, 4'b0001);
    tick();
    chk("rot_then3", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    repeat (3) tick();

    // Round-robin, all requesters valid, output always ready
    for (int i = 0; i < NREQ; i++) set_op(i, 16'hF900);
    req_valid = '1;
    snap_x = xfer_cnt;
    #1;
    for (int i = 0; i < 12; i++) begin
      chk("rr_grant", req_ready, 4'b0001 << (i % NREQ));
      if (i == 4) snap_r = rsp_cnt;
      tick();
    end
    chk("rr_xfers", xfer_cnt - snap_x, 12);
    chk("rr_rsp_rate", rsp_cnt - snap_r, 8);
    chk("rr_rsp_data", rsp_data, 16'h0000);
    req_valid = '0;
    repeat (3) tick();

    // Backpressure: only two acceptances with the output stalled
    for (int i = 0; i < NREQ; i++) set_op(i, W'($urandom));
    req_valid = '1;
    rsp_ready = 1'b0;
    snap_x = xfer_cnt;
    snap_r = rsp_cnt;
    repeat (6) tick();
    chk("bp_xfers", xfer_cnt - snap_x, 2);
    chk("bp_rdy_zero", req_ready, 0);
    chk("bp_rsp_valid", rsp_valid, 1'b1);
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) tick();
    chk("bp_rsp_count", rsp_cnt - snap_r, 2);
    chk("bp_sb_empty", sbq.size(), 0);

    // Reset with both stages full
    req_valid = '1;
    rsp_ready = 1'b0;
    repeat (3) tick();
    chk("mf_busy_before", busy, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_zero_state("mf_rst");
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mf_no_rsp", rsp_valid, 1'b0);
    end
    set_op(1, 16'h0123);
    req_valid = 4'b0010;
    #1;
    chk("mf_rdy1", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    tick();
    chk("mf_rsp_valid", rsp_valid, 1'b1);
    chk("mf_rsp_id", rsp_id, 1);
    chk("mf_rsp_data", rsp_data, sig(16'h0123));
    tick();

    // Randomized traffic with random output stalls
    for (int n = 0; n < 1500; n++) begin
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) set_op(i, W'($urandom));
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Drain with a bounded wait
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_n = 0;
    while ((sbq.size() != 0 || busy) && wait_n < 50) begin
      tick();
      wait_n++;
    end
    chk("drain_sb_empty", sbq.size(), 0);
    chk("drain_busy", busy, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
